reg_cmd_ctrl: RTL and testbench
===============================

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width.
REQ-002 SHALL have parameter REG_W, default 16, register width; it is fixed at two bytes.
REQ-003 SHALL have parameter DEPTH, default 8, number of valid register addresses.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle-cycle limit within a frame.
REQ-005 SHALL have port CLK, input, 1 bit: clock.
REQ-006 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port RX_P_DATA, input, 8 bits: received byte.
REQ-008 SHALL have port RX_D_VLD, input, 1 bit: one-cycle strobe qualifying RX_P_DATA.
REQ-009 SHALL have port WR_EN, output, 1 bit: register-file write strobe.
REQ-010 SHALL have port RD_EN, output, 1 bit: register-file read strobe.
REQ-011 SHALL have port ADDR, output, ADDR_W bits: register-file address.
REQ-012 SHALL have port WR_DATA, output, REG_W bits: register-file write data.
REQ-013 SHALL have port RD_DATA, input, REG_W bits: register-file read data.
REQ-014 SHALL have port RD_DATA_VLD, input, 1 bit: qualifies RD_DATA.
REQ-015 SHALL have port TX_P_DATA, output, 8 bits: response byte.
REQ-016 SHALL have port TX_D_VLD, output, 1 bit: response byte valid.
REQ-017 SHALL have port TX_BUSY, input, 1 bit: transmitter not ready.
REQ-018 SHALL have port CMD_ERR, output, 1 bit: one-cycle error pulse.

Function
REQ-019 SHALL decode frames: write = 0xAA, addr, data_lo, data_hi; read = 0xBB, addr.
REQ-020 SHALL implement the states IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, TX_LO and TX_HI.
REQ-021 SHALL sample a byte only in a cycle where RX_D_VLD=1; each sampled byte advances the state by one receive state.
REQ-022 SHALL, in IDLE, treat any command byte other than 0xAA/0xBB as an error: pulse CMD_ERR for 1 cycle and remain in IDLE.
REQ-023 SHALL use address byte bits[ADDR_W-1:0], ignore the upper bits, and abort the frame when that value is >= DEPTH (CMD_ERR pulse, no WR_EN/RD_EN, return to IDLE).
REQ-024 SHALL assert WR_EN for exactly 1 cycle, in the cycle after data_hi is sampled, with ADDR valid and WR_DATA = {data_hi, data_lo}, then return to IDLE.
REQ-025 SHALL assert RD_EN for exactly 1 cycle, in the cycle after a valid read address is sampled, then wait in RD_WAIT until RD_DATA_VLD=1 and capture RD_DATA in that cycle.
REQ-026 SHALL never assert WR_EN and RD_EN in the same cycle.
REQ-027 SHALL drive TX_D_VLD=1 from the cycle after capture, with TX_P_DATA = captured[7:0] first, then captured[15:8].
REQ-028 SHALL transfer a byte in any cycle with TX_D_VLD=1 and TX_BUSY=0, and SHALL hold TX_P_DATA/TX_D_VLD stable until that transfer.
REQ-029 SHALL return to IDLE after the high-byte transfer.
REQ-030 SHALL ignore and drop RX bytes received in WR_EXEC, RD_REQ, RD_WAIT, TX_LO and TX_HI.
REQ-031 SHALL register all outputs; ADDR and WR_DATA hold their last values between strobes.

Reset
REQ-032 SHALL, while RST=0, set the state to IDLE and all outputs (WR_EN, RD_EN, ADDR, WR_DATA, TX_P_DATA, TX_D_VLD, CMD_ERR) and the internal capture/counter registers to 0.
REQ-033 SHALL, on reset asserted mid-frame or mid-TX, abandon the frame; after release, no partial strobe or TX byte is issued.

Configuration
REQ-034 SHALL, with macro CMD_TIMEOUT_EN defined, count cycles without RX_D_VLD while in WR_ADDR, WR_DLO, WR_DHI or RD_ADDR, clearing the count on each sampled byte.
REQ-035 SHALL, with CMD_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES, return to IDLE and pulse CMD_ERR.
REQ-036 SHALL, without CMD_TIMEOUT_EN, wait indefinitely in receive states and contain no timeout counter.

Verification
REQ-037 SHALL cover: RX AA,03,34,12 -> one WR_EN pulse with ADDR=3, WR_DATA=0x1234 one cycle after byte 0x12.
REQ-038 SHALL cover: RX BB,03 with RD_DATA=0x1234 returned one cycle after RD_EN -> TX bytes 0x34 then 0x12.
REQ-039 SHALL cover: TX_BUSY=1 for 5 cycles during TX_LO -> TX_P_DATA=0x34 held stable, transferred only once TX_BUSY=0.
REQ-040 SHALL cover: RX 0x55 -> 1-cycle CMD_ERR pulse; RX AA,09 -> CMD_ERR, no WR_EN; RX AA,F2,.. -> address 2 is used.
REQ-041 SHALL cover: with CMD_TIMEOUT_EN, RX AA,01 followed by 1024 idle cycles -> CMD_ERR pulse and IDLE, after which a following BB,01 is decoded correctly.
REQ-042 SHALL cover: RST asserted after AA,05,FF -> all outputs 0; after release, RX 0x00 produces no WR_EN.

Source files
------------

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: byte-stream command decoder for a register file.
//   write frame: 0xAA, addr, data_lo, data_hi  -> one WR_EN strobe
//   read frame : 0xBB, addr                    -> RD_EN, then two TX bytes (lo, hi)
// Optional receive-timeout: define CMD_TIMEOUT_EN to abort frames that stall
// for TIMEOUT_CYCLES cycles inside a receive state.
`timescale 1ns/1ps

module reg_cmd_ctrl #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned REG_W          = 16,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_P_DATA,
    input  logic              RX_D_VLD,
    output logic              WR_EN,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [REG_W-1:0]  WR_DATA,
    input  logic [REG_W-1:0]  RD_DATA,
    input  logic              RD_DATA_VLD,
    output logic [7:0]        TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_BUSY,
    output logic              CMD_ERR
);

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC,
        RD_ADDR, RD_REQ, RD_WAIT, TX_LO, TX_HI
    } state_t;

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REG_W-1:0]    wr_data_q, wr_data_d;
    logic [7:0]          tx_p_data_q, tx_p_data_d;
    logic                tx_d_vld_q, tx_d_vld_d;
    logic                cmd_err_q, cmd_err_d;
    logic [ADDR_W-1:0]   addr_buf_q, addr_buf_d;
    logic [7:0]          data_lo_q, data_lo_d;
    logic [7:0]          rd_hi_q, rd_hi_d;

    logic [ADDR_W-1:0]   rx_addr;
    logic                rx_addr_bad;

    assign rx_addr     = RX_P_DATA[ADDR_W-1:0];
    assign rx_addr_bad = (32'(rx_addr) >= 32'(DEPTH));

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             rx_state;
    assign rx_state = (state_q == WR_ADDR) || (state_q == WR_DLO) ||
                      (state_q == WR_DHI)  || (state_q == RD_ADDR);
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        cmd_err_d   = 1'b0;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        tx_p_data_d = tx_p_data_q;
        tx_d_vld_d  = tx_d_vld_q;
        addr_buf_d  = addr_buf_q;
        data_lo_d   = data_lo_q;
        rd_hi_d     = rd_hi_q;

        unique case (state_q)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == CMD_WR)      state_d = WR_ADDR;
                else if (RX_P_DATA == CMD_RD) state_d = RD_ADDR;
                else                          cmd_err_d = 1'b1;
            end
            WR_ADDR: if (RX_D_VLD) begin
                if (rx_addr_bad) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    addr_buf_d = rx_addr;
                    state_d    = WR_DLO;
                end
            end
            WR_DLO: if (RX_D_VLD) begin
                data_lo_d = RX_P_DATA;
                state_d   = WR_DHI;
            end
            WR_DHI: if (RX_D_VLD) begin
                // ADDR/WR_DATA change only together with the strobe
                wr_en_d   = 1'b1;
                addr_d    = addr_buf_q;
                wr_data_d = REG_W'({RX_P_DATA, data_lo_q});
                state_d   = WR_EXEC;
            end
            WR_EXEC: state_d = IDLE;
            RD_ADDR: if (RX_D_VLD) begin
                if (rx_addr_bad) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = rx_addr;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: if (RD_DATA_VLD) begin
                rd_hi_d     = RD_DATA[REG_W-1 -: 8];
                tx_p_data_d = RD_DATA[7:0];
                tx_d_vld_d  = 1'b1;
                state_d     = TX_LO;
            end
            TX_LO: if (!TX_BUSY) begin
                tx_p_data_d = rd_hi_q;
                state_d     = TX_HI;
            end
            TX_HI: if (!TX_BUSY) begin
                tx_d_vld_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Stall watchdog for receive states; any sampled byte restarts it
        to_cnt_d = '0;
        if (rx_state && !RX_D_VLD) begin
            if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                cmd_err_d = 1'b1;
                state_d   = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            tx_p_data_q <= '0;
            tx_d_vld_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            addr_buf_q  <= '0;
            data_lo_q   <= '0;
            rd_hi_q     <= '0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            tx_p_data_q <= tx_p_data_d;
            tx_d_vld_q  <= tx_d_vld_d;
            cmd_err_q   <= cmd_err_d;
            addr_buf_q  <= addr_buf_d;
            data_lo_q   <= data_lo_d;
            rd_hi_q     <= rd_hi_d;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign WR_EN     = wr_en_q;
    assign RD_EN     = rd_en_q;
    assign ADDR      = addr_q;
    assign WR_DATA   = wr_data_q;
    assign TX_P_DATA = tx_p_data_q;
    assign TX_D_VLD  = tx_d_vld_q;
    assign CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: inputs driven at the falling edge,
// outputs sampled at the falling edge after each rising edge.
`timescale 1ns/1ps

module tb_reg_cmd_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned REG_W  = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic [7:0]        RX_P_DATA;
    logic              RX_D_VLD;
    logic              WR_EN;
    logic              RD_EN;
    logic [ADDR_W-1:0] ADDR;
    logic [REG_W-1:0]  WR_DATA;
    logic [REG_W-1:0]  RD_DATA;
    logic              RD_DATA_VLD;
    logic [7:0]        TX_P_DATA;
    logic              TX_D_VLD;
    logic              TX_BUSY;
    logic              CMD_ERR;

    int checks = 0;
    int errors = 0;

    reg_cmd_ctrl #(
        .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(8), .TIMEOUT_CYCLES(1024)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .WR_EN(WR_EN), .RD_EN(RD_EN), .ADDR(ADDR), .WR_DATA(WR_DATA),
        .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // Present one byte for a single cycle; returns at the falling edge after it was sampled
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    // Read frame with data returned the cycle after RD_EN, optional TX_BUSY stall on the low byte
    task automatic do_read(input logic [7:0] a, input logic [15:0] d, input int busy_cycles);
        TX_BUSY = (busy_cycles > 0);
        send_byte(8'hBB);
        send_byte(a);
        check("rd_en_pulse", 32'(RD_EN), 32'd1);
        check("rd_addr", 32'(ADDR), 32'(a[3:0]));
        check("rd_no_wr", 32'(WR_EN), 32'd0);
        @(negedge CLK);
        check("rd_en_single", 32'(RD_EN), 32'd0);
        check("tx_idle_wait", 32'(TX_D_VLD), 32'd0);
        RD_DATA     = d;
        RD_DATA_VLD = 1'b1;
        @(negedge CLK);
        RD_DATA_VLD = 1'b0;
        RD_DATA     = 16'h0;
        check("tx_lo_vld", 32'(TX_D_VLD), 32'd1);
        check("tx_lo_data", 32'(TX_P_DATA), 32'(d[7:0]));
        for (int i = 0; i < busy_cycles; i++) begin
            if (i == busy_cycles - 1) TX_BUSY = 1'b0;
            @(negedge CLK);
            if (i != busy_cycles - 1) begin
                check("tx_lo_hold_vld", 32'(TX_D_VLD), 32'd1);
                check("tx_lo_hold_data", 32'(TX_P_DATA), 32'(d[7:0]));
            end
        end
        if (busy_cycles == 0) @(negedge CLK);
        check("tx_hi_vld", 32'(TX_D_VLD), 32'd1);
        check("tx_hi_data", 32'(TX_P_DATA), 32'(d[15:8]));
        @(negedge CLK);
        check("tx_done", 32'(TX_D_VLD), 32'd0);
    endtask

    initial begin
        int err_at;
        RST = 1'b0;
        RX_P_DATA = 8'h0;
        RX_D_VLD = 1'b0;
        RD_DATA = 16'h0;
        RD_DATA_VLD = 1'b0;
        TX_BUSY = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_wr_en", 32'(WR_EN), 32'd0);
        check("rst_rd_en", 32'(RD_EN), 32'd0);
        check("rst_addr", 32'(ADDR), 32'd0);
        check("rst_wr_data", 32'(WR_DATA), 32'd0);
        check("rst_tx_data", 32'(TX_P_DATA), 32'd0);
        check("rst_tx_vld", 32'(TX_D_VLD), 32'd0);
        check("rst_cmd_err", 32'(CMD_ERR), 32'd0);
        RST = 1'b1;

        // Write AA,03,34,12
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h34);
        check("wr_early", 32'(WR_EN), 32'd0);
        send_byte(8'h12);
        check("wr_en", 32'(WR_EN), 32'd1);
        check("wr_addr", 32'(ADDR), 32'd3);
        check("wr_data", 32'(WR_DATA), 32'h1234);
        check("wr_no_rd", 32'(RD_EN), 32'd0);
        @(negedge CLK);
        check("wr_en_single", 32'(WR_EN), 32'd0);
        check("wr_data_hold", 32'(WR_DATA), 32'h1234);

        // Read BB,03 and the same with a 5-cycle transmitter stall
        do_read(8'h03, 16'h1234, 0);
        do_read(8'h03, 16'h1234, 6);

        // Bad command byte
        send_byte(8'h55);
        check("bad_cmd_err", 32'(CMD_ERR), 32'd1);
        @(negedge CLK);
        check("bad_cmd_err_single", 32'(CMD_ERR), 32'd0);

        // Out-of-range address aborts
        send_byte(8'hAA);
        send_byte(8'h09);
        check("bad_addr_err", 32'(CMD_ERR), 32'd1);
        check("bad_addr_no_wr", 32'(WR_EN), 32'd0);
        @(negedge CLK);
        check("bad_addr_no_wr2", 32'(WR_EN), 32'd0);

        // Upper address bits ignored: F2 -> 2
        send_byte(8'hAA);
        send_byte(8'hF2);
        send_byte(8'hCD);
        send_byte(8'hAB);
        check("hi_addr_wr_en", 32'(WR_EN), 32'd1);
        check("hi_addr_addr", 32'(ADDR), 32'd2);
        check("hi_addr_data", 32'(WR_DATA), 32'hABCD);

        // Stalled frame: timeout aborts when enabled, otherwise the frame resumes
        send_byte(8'hAA);
        send_byte(8'h01);
        err_at = 0;
        for (int i = 1; i <= 1100 && err_at == 0; i++) begin
            @(negedge CLK);
            if (CMD_ERR) err_at = i;
        end
`ifdef CMD_TIMEOUT_EN
        check("timeout_cycle", 32'(err_at), 32'd1024);
        do_read(8'h01, 16'h5678, 0);
`else
        check("no_timeout", 32'(err_at), 32'd0);
        send_byte(8'h34);
        send_byte(8'h12);
        check("stall_wr_en", 32'(WR_EN), 32'd1);
        check("stall_addr", 32'(ADDR), 32'd1);
        check("stall_data", 32'(WR_DATA), 32'h1234);
`endif

        // Reset in the middle of a write frame
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'hFF);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(WR_EN), 32'd0);
        check("mid_rst_addr", 32'(ADDR), 32'd0);
        check("mid_rst_wr_data", 32'(WR_DATA), 32'd0);
        check("mid_rst_tx", 32'({TX_D_VLD, TX_P_DATA}), 32'd0);
        check("mid_rst_err", 32'({CMD_ERR, RD_EN}), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        send_byte(8'h00);
        check("post_rst_no_wr", 32'(WR_EN), 32'd0);
        check("post_rst_err", 32'(CMD_ERR), 32'd1);
        @(negedge CLK);
        check("post_rst_no_wr2", 32'(WR_EN), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
